// File: rtl/rr_arbiter8.sv
// Eight-way round-robin arbiter. Each grant is held until done, until the owner
// drops its request, or until the hold limit is reached. The search start rotates after every release.
module rr_arbiter8 #(
  parameter int MAX_HOLD = 16
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] req,
  input  logic       done,
  output logic [7:0] gnt,
  output logic [2:0] gnt_id,
  output logic       busy,
  output logic       timeout
);

  typedef enum logic {IDLE, GRANT} state_t;

  state_t     state_reg, state_next;
  logic [2:0] ptr_reg, ptr_next;
  logic [7:0] cnt_reg, cnt_next;
  logic [7:0] gnt_reg, gnt_next;
  logic [2:0] id_reg, id_next;
  logic       timeout_reg, timeout_next;

  logic [7:0] rot_req;
  logic [2:0] low_idx;
  logic [2:0] win;
  logic       release_now;
  logic       forced;

  // Rotate the request vector so that bit 0 corresponds to requester ptr.
  generate
    for (genvar gi = 0; gi < 8; gi++) begin : g_rot
      assign rot_req[gi] = req[3'(gi) + ptr_reg];
    end
  endgenerate

  always_comb begin
    low_idx = 3'd0;
    for (int i = 7; i >= 0; i--) begin
      if (rot_req[i]) low_idx = 3'(i);
    end
  end

  assign win = low_idx + ptr_reg;

  assign release_now = done || !req[id_reg] || (cnt_reg == 8'(MAX_HOLD));
  // The hold limit only counts as a timeout when neither done nor abandon applies.
  assign forced      = !done && req[id_reg] && (cnt_reg == 8'(MAX_HOLD));

  always_comb begin
    state_next   = state_reg;
    ptr_next     = ptr_reg;
    cnt_next     = cnt_reg;
    gnt_next     = gnt_reg;
    id_next      = id_reg;
    timeout_next = 1'b0;
    case (state_reg)
      IDLE: begin
        if (|req) begin
          state_next = GRANT;
          gnt_next   = 8'b1 << win;
          id_next    = win;
          cnt_next   = 8'd1;
        end else begin
          gnt_next = 8'd0;
          id_next  = 3'd0;
          cnt_next = 8'd0;
        end
      end
      GRANT: begin
        if (release_now) begin
          state_next   = IDLE;
          gnt_next     = 8'd0;
          id_next      = 3'd0;
          cnt_next     = 8'd0;
          ptr_next     = id_reg + 3'd1;
          timeout_next = forced;
        end else begin
          cnt_next = cnt_reg + 8'd1;
        end
      end
      default: begin
        state_next = IDLE;
        gnt_next   = 8'd0;
        id_next    = 3'd0;
        cnt_next   = 8'd0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_reg   <= IDLE;
      ptr_reg     <= 3'd0;
      cnt_reg     <= 8'd0;
      gnt_reg     <= 8'd0;
      id_reg      <= 3'd0;
      timeout_reg <= 1'b0;
    end else begin
      state_reg   <= state_next;
      ptr_reg     <= ptr_next;
      cnt_reg     <= cnt_next;
      gnt_reg     <= gnt_next;
      id_reg      <= id_next;
      timeout_reg <= timeout_next;
    end
  end

  assign gnt     = gnt_reg;
  assign gnt_id  = id_reg;
  assign busy    = |gnt_reg;
  assign timeout = timeout_reg;

endmodule
